// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared FSM encoding and frame constants for the serial frame receiver
// Purpose: state type and start/stop bit levels used across the receiver.
// Ports: none (package).
package serial_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_shift_reg.sv
// rtl/rx_shift_reg.sv - WIDTH-bit serial-in parallel-out shift register with clear
// Purpose: collects serial data MSB first; each enabled cycle shifts left with din entering bit 0.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (clears q)
//   clr  - synchronous clear (same effect as rst)
//   en   - shift enable
//   din  - serial data in
//   q    - parallel register contents
module rx_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - start/data/stop serial frame receiver with a one-entry holding register
// Purpose: receives frames (start 0, WIDTH data bits MSB first, stop 1), one bit per clk,
//          and presents each good payload through a valid/ready holding register.
// Ports:
//   clk       - clock, all state updates on rising edge
//   rst       - synchronous active-high reset
//   sin       - serial line, idles high
//   out_data  - received payload
//   out_valid - out_data holds an unconsumed frame
//   out_ready - consumer accepts out_data this cycle
//   frame_err - one-cycle pulse after a bad stop bit
//   overrun   - sticky: a good frame was dropped because the holding register was full
module serial_frame_receiver
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_t        state, state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sh_q;
  logic             sh_clr;
  logic             sh_en;
  logic             load;
  logic             drop;
  logic             bad_stop;
  logic             hold_free;

  // The holding register can take a new frame if empty, or if the current
  // frame is being consumed in the same cycle.
  assign hold_free = !out_valid || out_ready;

  rx_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk (clk),
    .rst (rst),
    .clr (sh_clr),
    .en  (sh_en),
    .din (sin),
    .q   (sh_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sh_clr    = 1'b0;
    sh_en     = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sin == START_BIT) begin
          state_nxt = ST_DATA;
          sh_clr    = 1'b1;
        end
      end
      ST_DATA: begin
        sh_en = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Always return to IDLE: a low stop bit is not treated as a new start.
        state_nxt = ST_IDLE;
        if (sin == STOP_BIT) begin
          if (hold_free) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else begin
          bad_stop = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sh_clr) begin
        bit_cnt <= '0;
      end else if (sh_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      frame_err <= bad_stop;

      if (load) begin
        out_data  <= sh_q;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - randomized self-checking bench for serial_frame_receiver
module tb_serial_frame_receiver;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         sin;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         frame_err;
  logic         overrun;

  int vectors;
  int miscompares;
  int cycle;

  // Reference: the bench knows which cycle carries each stop bit and its payload,
  // so the holding register is modelled per frame event, not per bit.
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_err;
  logic         m_ovr;

  serial_frame_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input bit stop_evt, input bit good, input logic [W-1:0] pay);
    @(posedge clk);
    cycle++;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_err   = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      m_err = stop_evt && !good;
      if (stop_evt && good) begin
        if (!m_valid || out_ready) begin
          m_data  = pay;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== m_valid) begin
      miscompares++;
      $display("FAIL valid cycle %0d: got %b expected %b", cycle, out_valid, m_valid);
    end
    vectors++;
    if (out_data !== m_data) begin
      miscompares++;
      $display("FAIL data cycle %0d: got %h expected %h", cycle, out_data, m_data);
    end
    vectors++;
    if (frame_err !== m_err) begin
      miscompares++;
      $display("FAIL frame_err cycle %0d: got %b expected %b", cycle, frame_err, m_err);
    end
    vectors++;
    if (overrun !== m_ovr) begin
      miscompares++;
      $display("FAIL overrun cycle %0d: got %b expected %b", cycle, overrun, m_ovr);
    end
  endtask

  // mode 0: ready low, 1: ready high, 2: random, 3: ready only on the stop-bit cycle
  function automatic logic pick_ready(input int mode, input bit is_stop);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return is_stop ? 1'b1 : 1'b0;
    endcase
  endfunction

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      sin       = 1'b1;
      out_ready = pick_ready(mode == 3 ? 0 : mode, 1'b0);
      tick(1'b0, 1'b0, '0);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] pay, input bit good, input int mode);
    sin       = 1'b0;
    out_ready = pick_ready(mode, 1'b0);
    tick(1'b0, 1'b0, '0);
    for (int i = W - 1; i >= 0; i--) begin
      sin       = pay[i];
      out_ready = pick_ready(mode, 1'b0);
      tick(1'b0, 1'b0, '0);
    end
    sin       = good;
    out_ready = pick_ready(mode, 1'b1);
    tick(1'b1, good, pay);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    sin       = 1'b1;
    out_ready = 1'b0;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    sin       = 1'b0;
    out_ready = 1'b1;
    tick(1'b0, 1'b0, '0);
    rst = 1'b0;
    idle(2, 0);
  endtask

  task automatic test_single_frame();
    do_reset();
    idle(2, 0);
    send_frame(4'b1011, 1'b1, 0);
    idle(4, 0);
    vectors++;
    if (out_data !== 4'b1011 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_hold: got data %b valid %b expected 1011 1", out_data, out_valid);
    end
    idle(2, 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    idle(1, 1);
    send_frame(4'b1010, 1'b1, 1);
    send_frame(4'b0110, 1'b1, 1);
    idle(3, 1);
  endtask

  task automatic test_overrun();
    do_reset();
    idle(1, 0);
    send_frame(4'b1100, 1'b1, 0);
    send_frame(4'b0011, 1'b1, 0);
    idle(2, 0);
    idle(1, 1);
    idle(3, 0);
  endtask

  task automatic test_frame_error();
    do_reset();
    idle(1, 0);
    send_frame(4'b1111, 1'b0, 0);
    idle(W + 4, 0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    idle(1, 0);
    sin = 1'b0;
    tick(1'b0, 1'b0, '0);
    sin = 1'b1;
    tick(1'b0, 1'b0, '0);
    sin = 1'b0;
    tick(1'b0, 1'b0, '0);
    rst = 1'b1;
    sin = 1'b1;
    tick(1'b0, 1'b0, '0);
    rst = 1'b0;
    idle(2, 0);
    send_frame(4'b0101, 1'b1, 0);
    idle(W + 3, 0);
    idle(1, 1);
  endtask

  task automatic test_simultaneous();
    do_reset();
    idle(1, 0);
    send_frame(4'b0110, 1'b1, 0);
    send_frame(4'b1001, 1'b1, 3);
    idle(2, 0);
    idle(1, 1);
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 60; f++) begin
      logic [W-1:0] pay;
      bit           good;
      pay  = W'($urandom);
      good = ($urandom_range(0, 99) < 85);
      send_frame(pay, good, 2);
      idle($urandom_range(0, 3), 2);
      if (f == 30) do_reset();
    end
    idle(4, 1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_err       = 1'b0;
    m_ovr       = 1'b0;
    rst         = 1'b1;
    sin         = 1'b1;
    out_ready   = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_reset_mid_frame();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 Parameter: WIDTH, default 4, number of data bits per frame (legal 2..16).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 sin  input  1  serial line; idles high; one bit per clk cycle.
REQ-005 out_data  output  WIDTH  received frame payload.
REQ-006 out_valid  output  1  out_data holds an unconsumed frame.
REQ-007 out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 frame_err  output  1  one-cycle pulse: bad stop bit.
REQ-009 overrun  output  1  sticky: a good frame was dropped because the holding register was full.

Function
REQ-010 Frame format SHALL be: start bit 0, WIDTH data bits MSB first, stop bit 1, with each bit occupying exactly one clk cycle.
REQ-011 FSM states SHALL be IDLE, DATA, and STOP, with a 2-bit state encoding.
REQ-012 IDLE: sin=0 SHALL go to DATA with the bit counter cleared; sin=1 SHALL stay in IDLE.
REQ-013 DATA: each cycle, the shift register SHALL shift left with sin entering bit 0 and the bit counter SHALL increment; after the WIDTH-th bit, the FSM SHALL go to STOP.
REQ-014 After WIDTH data bits, the first-received bit SHALL occupy bit WIDTH-1.
REQ-015 STOP with sin=1 and the holding register free SHALL load the shift register into out_data and set out_valid the next cycle; the FSM SHALL go to IDLE.
REQ-016 Latency from the stop-bit sampling edge to out_valid=1 SHALL be 1 cycle.
REQ-017 "Free" SHALL mean out_valid=0, or out_valid=1 with out_ready=1 in the same cycle; in the latter case the new data SHALL be loaded and out_valid SHALL remain 1.
REQ-018 STOP with sin=1 and the holding register not free SHALL drop the new frame, leave out_data unchanged, and set overrun; the FSM SHALL go to IDLE.
REQ-019 STOP with sin=0 SHALL pulse frame_err for exactly one cycle, discard the shifted data, and go to IDLE; that sin=0 SHALL NOT count as a start bit.
REQ-020 A start bit SHALL be accepted the cycle immediately after a good stop bit, allowing back-to-back frames.
REQ-021 out_valid=1 with out_ready=1 and no new load SHALL clear out_valid the next cycle.
REQ-022 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 out_ready while out_valid=0 SHALL be ignored.
REQ-024 overrun SHALL remain set until rst.

Reset
REQ-025 rst=1 at a clk edge SHALL force state=IDLE, bit counter=0, shift register=0, out_data=0, out_valid=0, frame_err=0, overrun=0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no out_valid and no frame_err; reception SHALL restart only on a start bit sampled after rst deasserts.
REQ-027 rst SHALL take priority over every other input.

Structure
REQ-028 The FSM state encodings and the frame format constants (start=0, stop=1) SHALL reside in the shared package serial_frame_pkg.
REQ-029 A single sub-module, rx_shift_reg, SHALL be used: a WIDTH-bit SIPO register with shift-enable and clear.
REQ-030 Bit counter width SHALL be clog2(WIDTH+1).

Verification
REQ-031 Single frame: idle, then sin = 0,1,0,1,1,1 with WIDTH=4 and out_ready=0 -> out_data=4'b1011 and out_valid=1 one cycle after the stop bit, held stable until out_ready=1.
REQ-032 Back-to-back frames: 1010 then 0110 with out_ready=1 continuously -> out_valid for 1010, then for 0110, with overrun=0 and frame_err=0.
REQ-033 Overrun: two frames, 1100 then 0011, with out_ready=0 -> out_data stays 1100 and overrun=1; a later handshake clears out_valid and overrun stays 1.
REQ-034 Framing error: start, 1111, stop bit 0 -> frame_err pulses for exactly one cycle, out_valid stays 0, and the FSM returns to IDLE without starting a new frame.
REQ-035 Reset mid-frame: rst for 1 cycle after 2 data bits, then a full frame 0101 -> only 0101 is delivered, with no frame_err.
REQ-036 Simultaneous events: the stop bit of 1001 is sampled in the same cycle as an out_ready handshake of the prior frame -> 1001 is loaded, out_valid stays 1, and overrun=0.
